if_id_buffer: RTL and testbench
===============================

// Module: if_id_buffer
// PURPOSE
//   Decoupling buffer between the IF stage and the ID stage.
//   - Captures each completed fetch: instruction, PC, PC+4, trap flag, trap code.
//   - Presents entries in order to ID through a valid/ready handshake.
//   - Back-pressures IF via fetch_hold_o (IF gates PC_en with it).
//   - Flushes the wrong path on a jump/branch/trap redirect.
// PARAMETERS
//   DEPTH      2             number of entries; power of two, >= 2
//   NOP_INSTR  32'h0000_0013 instruction driven to ID when empty (addi x0,x0,0)
// PORTS
//   clk_i            in   1   clock
//   rst_i            in   1   reset, asynchronous, active-high
//   fetch_valid_i    in   1   one-cycle pulse: IF completed a fetch (ack or err)
//   instr_if_i       in   32  fetched instruction
//   PC_if_i          in   32  PC of the fetched instruction
//   PC4_if_i         in   32  PC+4 of the fetched instruction
//   is_trap_if_i     in   1   fetch raised a trap
//   trap_code_if_i   in   4   trap code (0 = misaligned, 1 = access fault)
//   flush_i          in   1   redirect: discard all entries
//   id_ready_i       in   1   ID accepts the head entry this cycle
//   fetch_hold_o     out  1   IF must not advance the PC
//   id_valid_o       out  1   head entry valid
//   instr_id_o       out  32  head instruction (NOP_INSTR when empty)
//   PC_id_o          out  32  head PC (0 when empty)
//   PC4_id_o         out  32  head PC+4 (0 when empty)
//   is_trap_id_o     out  1   head trap flag (0 when empty)
//   trap_code_id_o   out  4   head trap code (0 when empty)
//   count_o          out  $clog2(DEPTH)+1  occupancy
// BEHAVIOUR
//   - Reset, asynchronous: wr_ptr = rd_ptr = count = 0, trap_pending = 0.
//     All outputs take their empty values: id_valid_o = 0, instr_id_o = NOP_INSTR,
//     other data outputs 0, fetch_hold_o = 0.
//   - Storage: circular buffer, log2(DEPTH)-bit pointers, wrap DEPTH-1 -> 0.
//     Entry width is 32+32+32+1+4 = 101 bits.
//   - Outputs are show-ahead: a combinational mux of entry[rd_ptr] when count != 0.
//     No reset is needed on storage; outputs are forced to empty values when count == 0.
//   - Signal definitions:
//       push = fetch_valid_i & ~flush_i & ~trap_pending & (count < DEPTH | pop)
//       pop  = id_valid_o & id_ready_i & ~flush_i
//   - Latency: an entry pushed at edge N is visible at the ID outputs after edge N.
//     That is one cycle. There is no same-cycle bypass.
//   - Simultaneous push and pop: both pointers advance and count is unchanged.
//     This includes the full case, so a full buffer with a pop accepts a push.
//   - Push attempted while full with no pop: the push is dropped and nothing changes.
//     IF must never do this; the bench asserts it as an error.
//   - Pop while empty: ignored, because id_valid_o = 0.
//   - Flush: at the next edge, pointers, count and trap_pending clear to 0.
//     It overrides push and pop in the same cycle; the incoming fetch is wrong-path and is discarded.
//   - Trap entry: pushing an entry with is_trap_if_i = 1 sets trap_pending.
//     While trap_pending = 1, further pushes are ignored.
//     trap_pending clears only on flush or reset; the trap redirect always flushes.
//   - Hold output: fetch_hold_o = (count == DEPTH) | trap_pending.
//     It is a combinational function of registers only, so there is no path from id_ready_i.
//   - count_o = count, range 0..DEPTH.
// TESTING
//   1. Reset mid-stream: rst_i asserted with count = 2, no clock edge
//      -> id_valid_o = 0, instr_id_o = 32'h13, fetch_hold_o = 0 immediately.
//   2. Fill and stall: three fetches (PC 0x0, 0x4, 0x8), id_ready_i = 0
//      -> count_o = 2 and fetch_hold_o = 1 after the 2nd push; 0x8 is dropped and flagged;
//      head PC_id_o = 0x0.
//   3. Full push+pop: count = 2, push PC 0xC, pop head 0x0 in the same cycle
//      -> count_o stays 2; later pops yield PC 0x4 then 0xC; pointer wrap is exercised.
//   4. Flush with push: count = 1, flush_i = 1 with fetch_valid_i = 1 (PC 0x20)
//      -> next cycle count_o = 0 and id_valid_o = 0; PC 0x20 is never presented.
//   5. Trap entry: push is_trap = 1, code 1 at PC 0x40, then push PC 0x44
//      -> 0x44 is ignored and fetch_hold_o = 1 until flush_i; head shows
//      is_trap_id_o = 1, trap_code_id_o = 4'd1.
//   6. Streaming: fetch_valid_i and id_ready_i high every cycle for 8 cycles
//      -> PCs 0x0..0x1C emerge in order, one per cycle, after 1 cycle latency;
//      count_o stays 1.

Source files
------------

// File: rtl/if_id_buffer.sv
// rtl/if_id_buffer.sv - IF/ID decoupling buffer: show-ahead circular queue with flush and trap hold
module if_id_buffer #(
    parameter int          DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       fetch_valid_i,
    input  logic [31:0]                instr_if_i,
    input  logic [31:0]                PC_if_i,
    input  logic [31:0]                PC4_if_i,
    input  logic                       is_trap_if_i,
    input  logic [3:0]                 trap_code_if_i,
    input  logic                       flush_i,
    input  logic                       id_ready_i,
    output logic                       fetch_hold_o,
    output logic                       id_valid_o,
    output logic [31:0]                instr_id_o,
    output logic [31:0]                PC_id_o,
    output logic [31:0]                PC4_id_o,
    output logic                       is_trap_id_o,
    output logic [3:0]                 trap_code_id_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        trap;
        logic [3:0]  code;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            trap_pending_q, trap_pending_d;
    logic            push, pop;
    entry_t          head;

    assign id_valid_o = (count_q != '0);
    assign pop        = id_valid_o & id_ready_i & ~flush_i;
    assign push       = fetch_valid_i & ~flush_i & ~trap_pending_q &
                        ((count_q < CW'(DEPTH)) | pop);

    // Hold depends only on registers so id_ready_i never reaches the PC enable.
    assign fetch_hold_o = (count_q == CW'(DEPTH)) | trap_pending_q;
    assign count_o      = count_q;

    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        trap_pending_d = trap_pending_q;
        if (flush_i) begin
            wr_ptr_d       = '0;
            rd_ptr_d       = '0;
            count_d        = '0;
            trap_pending_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
                if (is_trap_if_i) trap_pending_d = 1'b1;
            end
            if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            trap_pending_q <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            trap_pending_q <= trap_pending_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= '{instr: instr_if_i, pc: PC_if_i, pc4: PC4_if_i,
                                       trap: is_trap_if_i, code: trap_code_if_i};
    end

    always_comb begin
        head           = mem_q[rd_ptr_q];
        instr_id_o     = NOP_INSTR;
        PC_id_o        = '0;
        PC4_id_o       = '0;
        is_trap_id_o   = 1'b0;
        trap_code_id_o = '0;
        if (id_valid_o) begin
            instr_id_o     = head.instr;
            PC_id_o        = head.pc;
            PC4_id_o       = head.pc4;
            is_trap_id_o   = head.trap;
            trap_code_id_o = head.code;
        end
    end
endmodule

// File: tb/tb_if_id_buffer.sv
// tb/tb_if_id_buffer.sv - scoreboard bench for if_id_buffer with directed fetch/flush/trap vectors
module tb_if_id_buffer;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        fetch_valid_i;
    logic [31:0] instr_if_i, PC_if_i, PC4_if_i;
    logic        is_trap_if_i;
    logic [3:0]  trap_code_if_i;
    logic        flush_i, id_ready_i;
    logic        fetch_hold_o, id_valid_o;
    logic [31:0] instr_id_o, PC_id_o, PC4_id_o;
    logic        is_trap_id_o;
    logic [3:0]  trap_code_id_o;
    logic [1:0]  count_o;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        trap;
        logic [3:0]  code;
    } ent_t;

    ent_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   viol  = 0;

    always #5 clk_i = ~clk_i;

    if_id_buffer #(.DEPTH(2), .NOP_INSTR(32'h0000_0013)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .fetch_valid_i(fetch_valid_i),
        .instr_if_i(instr_if_i), .PC_if_i(PC_if_i), .PC4_if_i(PC4_if_i),
        .is_trap_if_i(is_trap_if_i), .trap_code_if_i(trap_code_if_i),
        .flush_i(flush_i), .id_ready_i(id_ready_i), .fetch_hold_o(fetch_hold_o),
        .id_valid_o(id_valid_o), .instr_id_o(instr_id_o), .PC_id_o(PC_id_o),
        .PC4_id_o(PC4_id_o), .is_trap_id_o(is_trap_id_o),
        .trap_code_id_o(trap_code_id_o), .count_o(count_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    // Drive one fetch for the coming edge; 'expect_acc' queues it on the scoreboard.
    task automatic fetch(input logic [31:0] pc, input logic trap, input logic [3:0] code,
                         input bit expect_acc);
        ent_t e;
        fetch_valid_i  = 1'b1;
        PC_if_i        = pc;
        PC4_if_i       = pc + 32'd4;
        instr_if_i     = 32'hA000_0000 | pc;
        is_trap_if_i   = trap;
        trap_code_if_i = code;
        if (expect_acc) begin
            e = '{instr: 32'hA000_0000 | pc, pc: pc, pc4: pc + 32'd4, trap: trap, code: code};
            exp_q.push_back(e);
        end
    endtask

    task automatic idle();
        fetch_valid_i  = 1'b0;
        is_trap_if_i   = 1'b0;
        trap_code_if_i = 4'd0;
    endtask

    // Monitor: compare the head against the scoreboard whenever ID takes it.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (fetch_valid_i && !flush_i && count_o == 2'd2 && !(id_valid_o && id_ready_i)) begin
                viol++;
                $display("note: protocol violation, push while full dropped (PC %h)", PC_if_i);
            end
            if (id_valid_o && id_ready_i && !flush_i) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL pop_unexpected: got PC %h expected no entry", PC_id_o);
                end else begin
                    ent_t e;
                    e = exp_q.pop_front();
                    if (PC_id_o !== e.pc || PC4_id_o !== e.pc4 || instr_id_o !== e.instr ||
                        is_trap_id_o !== e.trap || trap_code_id_o !== e.code) begin
                        n_err++;
                        $display("FAIL pop_entry: got pc=%h pc4=%h ins=%h trap=%b code=%h expected pc=%h pc4=%h ins=%h trap=%b code=%h",
                                 PC_id_o, PC4_id_o, instr_id_o, is_trap_id_o, trap_code_id_o,
                                 e.pc, e.pc4, e.instr, e.trap, e.code);
                    end
                end
            end
        end
    end

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; id_ready_i = 1'b0;
        PC_if_i = '0; PC4_if_i = '0; instr_if_i = '0;
        idle();
        #3;
        chk("rst_valid", 32'(id_valid_o), 32'd0);
        chk("rst_instr", instr_id_o, 32'h13);
        chk("rst_hold", 32'(fetch_hold_o), 32'd0);
        chk("rst_count", 32'(count_o), 32'd0);
        cyc(); cyc();
        rst_i = 1'b0;

        // Reset mid-stream with two entries held
        fetch(32'h100, 1'b0, 4'd0, 1'b1); cyc();
        fetch(32'h104, 1'b0, 4'd0, 1'b1); cyc();
        idle();
        chk("mid_count_pre", 32'(count_o), 32'd2);
        rst_i = 1'b1;
        #1;
        chk("mid_valid", 32'(id_valid_o), 32'd0);
        chk("mid_instr", instr_id_o, 32'h13);
        chk("mid_hold", 32'(fetch_hold_o), 32'd0);
        chk("mid_count", 32'(count_o), 32'd0);
        exp_q.delete();
        cyc();
        rst_i = 1'b0;

        // Fill and stall
        fetch(32'h0, 1'b0, 4'd0, 1'b1); cyc();
        chk("fill1_count", 32'(count_o), 32'd1);
        chk("fill1_hold", 32'(fetch_hold_o), 32'd0);
        fetch(32'h4, 1'b0, 4'd0, 1'b1); cyc();
        chk("fill2_count", 32'(count_o), 32'd2);
        chk("fill2_hold", 32'(fetch_hold_o), 32'd1);
        fetch(32'h8, 1'b0, 4'd0, 1'b0); cyc();
        idle();
        chk("drop_count", 32'(count_o), 32'd2);
        chk("drop_head_pc", PC_id_o, 32'h0);
        chk("drop_flagged", 32'(viol), 32'd1);

        // Full push+pop, then drain across the pointer wrap
        fetch(32'hC, 1'b0, 4'd0, 1'b1);
        id_ready_i = 1'b1;
        cyc();
        idle();
        chk("fullpp_count", 32'(count_o), 32'd2);
        cyc(); cyc();
        id_ready_i = 1'b0;
        chk("drain_count", 32'(count_o), 32'd0);
        chk("drain_valid", 32'(id_valid_o), 32'd0);
        chk("drain_instr", instr_id_o, 32'h13);

        // Flush with a concurrent wrong-path fetch
        fetch(32'h10, 1'b0, 4'd0, 1'b1); cyc();
        chk("flush_pre_count", 32'(count_o), 32'd1);
        flush_i = 1'b1;
        fetch(32'h20, 1'b0, 4'd0, 1'b0);
        exp_q.delete();
        cyc();
        flush_i = 1'b0;
        idle();
        id_ready_i = 1'b1;
        chk("flush_count", 32'(count_o), 32'd0);
        chk("flush_valid", 32'(id_valid_o), 32'd0);
        cyc();
        chk("flush_valid2", 32'(id_valid_o), 32'd0);
        id_ready_i = 1'b0;

        // Trap entry blocks further pushes until flush
        fetch(32'h40, 1'b1, 4'd1, 1'b1); cyc();
        chk("trap_hold", 32'(fetch_hold_o), 32'd1);
        chk("trap_flag", 32'(is_trap_id_o), 32'd1);
        chk("trap_code", 32'(trap_code_id_o), 32'd1);
        fetch(32'h44, 1'b0, 4'd0, 1'b0); cyc();
        idle();
        chk("trap_ign_count", 32'(count_o), 32'd1);
        chk("trap_ign_pc", PC_id_o, 32'h40);
        id_ready_i = 1'b1;
        cyc();
        id_ready_i = 1'b0;
        chk("trap_pop_count", 32'(count_o), 32'd0);
        chk("trap_hold_after_pop", 32'(fetch_hold_o), 32'd1);
        flush_i = 1'b1;
        exp_q.delete();
        cyc();
        flush_i = 1'b0;
        chk("trap_hold_cleared", 32'(fetch_hold_o), 32'd0);

        // Streaming at one entry per cycle
        id_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            fetch(32'(i * 4), 1'b0, 4'd0, 1'b1);
            cyc();
            chk($sformatf("stream_count_%0d", i), 32'(count_o), 32'd1);
            chk($sformatf("stream_head_%0d", i), PC_id_o, 32'(i * 4));
        end
        idle();
        cyc();
        id_ready_i = 1'b0;
        chk("stream_end_count", 32'(count_o), 32'd0);
        chk("stream_sb_empty", 32'(exp_q.size()), 32'd0);

        cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
